// File: rtl/chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub
// Purpose  : Multi-cycle add/subtract unit for the RV32I datapath. Operands
//            are summed CHUNK_SIZE bits per cycle through a registered carry,
//            so the carry path never spans more than one chunk. Produces
//            carry, signed overflow, zero and negative flags. Valid/ready
//            handshake on both sides; one operation in flight at a time.
// Options  : `define CHUNKED_ADD_SUB_SAT_EN to replace an overflowing result
//            with the signed saturation value (flags follow the saturated
//            value, carry is unaffected).
// Revision : 1.0 - initial release
// ============================================================================
module chunked_add_sub #(
  parameter int NUM_SIZE   = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                inValid,
  output logic                inReady,
  input  logic                add,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] dOut,
  output logic                carry,
  output logic                overflow,
  output logic                zero,
  output logic                negative
);

  // --------------------------------------------------------------------------
  // Derived sizes and state encoding
  // --------------------------------------------------------------------------
  localparam int NUM_CHUNKS = NUM_SIZE / CHUNK_SIZE;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  localparam logic [CNT_W-1:0] c_last_chunk = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_busy = 2'd1;
  localparam logic [1:0] c_state_done = 2'd2;

  // A width that does not split evenly into chunks cannot be processed.
  generate
    if ((CHUNK_SIZE < 1) || ((NUM_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_chunk_size
      $error("chunked_add_sub: NUM_SIZE must be a positive multiple of CHUNK_SIZE");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  // Operand registers shift right one chunk per BUSY cycle so the chunk being
  // summed is always in the low bits; no variable part-select is needed.
  logic [NUM_SIZE-1:0] a_q,      a_d;
  logic [NUM_SIZE-1:0] b_q,      b_d;
  // Sum bits enter at the top and shift down; after NUM_CHUNKS cycles the
  // first chunk has reached bit 0 and the result is aligned.
  logic [NUM_SIZE-1:0] acc_q,    acc_d;
  logic                cy_q,     cy_d;
  // Sign bits of A and effective B, kept for the overflow decision because
  // the operand registers are consumed by the shifting.
  logic                a_msb_q,  a_msb_d;
  logic                b_msb_q,  b_msb_d;
  // Presented result and flags, loaded once when the last chunk completes.
  logic [NUM_SIZE-1:0] dout_q,   dout_d;
  logic                carry_q,  carry_d;
  logic                ovf_q,    ovf_d;
  logic                zero_q,   zero_d;
  logic                neg_q,    neg_d;

  // --------------------------------------------------------------------------
  // Chunk datapath
  // --------------------------------------------------------------------------
  logic [CHUNK_SIZE:0]   w_chunk_sum;
  logic [NUM_SIZE-1:0]   w_a_shift;
  logic [NUM_SIZE-1:0]   w_b_shift;
  logic [NUM_SIZE-1:0]   w_acc_shift;
  logic                  w_ovf;
  logic [NUM_SIZE-1:0]   w_final;

  // One chunk of A plus one chunk of effective B plus the registered carry.
  assign w_chunk_sum = {1'b0, a_q[CHUNK_SIZE-1:0]}
                     + {1'b0, b_q[CHUNK_SIZE-1:0]}
                     + {{CHUNK_SIZE{1'b0}}, cy_q};

  generate
    if (NUM_CHUNKS == 1) begin : g_single_chunk
      // Whole word handled in one step: nothing remains to shift.
      assign w_a_shift   = '0;
      assign w_b_shift   = '0;
      assign w_acc_shift = w_chunk_sum[CHUNK_SIZE-1:0];
    end else begin : g_multi_chunk
      assign w_a_shift   = {{CHUNK_SIZE{1'b0}}, a_q[NUM_SIZE-1:CHUNK_SIZE]};
      assign w_b_shift   = {{CHUNK_SIZE{1'b0}}, b_q[NUM_SIZE-1:CHUNK_SIZE]};
      assign w_acc_shift = {w_chunk_sum[CHUNK_SIZE-1:0], acc_q[NUM_SIZE-1:CHUNK_SIZE]};
    end
  endgenerate

  // Signed overflow: like-signed operands producing a result of the other sign.
  // Only meaningful on the last BUSY cycle, when w_acc_shift is the full sum.
  assign w_ovf = (a_msb_q == b_msb_q) && (w_acc_shift[NUM_SIZE-1] != a_msb_q);

`ifdef CHUNKED_ADD_SUB_SAT_EN
  // On overflow clamp toward the sign of A (the true result's sign).
  assign w_final = !w_ovf   ? w_acc_shift :
                   a_msb_q  ? {1'b1, {(NUM_SIZE-1){1'b0}}} :
                              {1'b0, {(NUM_SIZE-1){1'b1}}};
`else
  assign w_final = w_acc_shift;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic: accept in IDLE, one chunk per BUSY cycle, hold in DONE
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      c_state_idle: begin
        if (inValid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = dIn0;
          b_d     = add ? dIn1 : ~dIn1;
          cy_d    = ~add;
          a_msb_d = dIn0[NUM_SIZE-1];
          b_msb_d = add ? dIn1[NUM_SIZE-1] : ~dIn1[NUM_SIZE-1];
          cnt_d   = '0;
          state_d = c_state_busy;
        end
      end

      c_state_busy: begin
        a_d   = w_a_shift;
        b_d   = w_b_shift;
        acc_d = w_acc_shift;
        cy_d  = w_chunk_sum[CHUNK_SIZE];
        if (cnt_q == c_last_chunk) begin
          dout_d  = w_final;
          carry_d = w_chunk_sum[CHUNK_SIZE];
          ovf_d   = w_ovf;
          zero_d  = (w_final == '0);
          neg_d   = w_final[NUM_SIZE-1];
          state_d = c_state_done;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      c_state_done: begin
        // Result and flags are held in registers until the consumer takes them.
        if (outReady) begin
          state_d = c_state_idle;
        end
      end

      default: begin
        state_d = c_state_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers with synchronous active-low reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= c_state_idle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign inReady  = (state_q == c_state_idle);
  assign outValid = (state_q == c_state_done);
  assign dOut     = dout_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_add_sub
// Purpose  : Self-checking bench for chunked_add_sub (32-bit, 8-bit chunks).
//            A signed/unsigned arithmetic model predicts every result and its
//            arrival cycle; directed cases pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_add_sub;
  localparam int NS  = 32;
  localparam int CS  = 8;
  localparam int NCH = NS / CS;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          inValid = 1'b0;
  logic          add = 1'b0;
  logic          outReady = 1'b0;
  logic [NS-1:0] dIn0 = '0;
  logic [NS-1:0] dIn1 = '0;
  logic          inReady, outValid, carry, overflow, zero, negative;
  logic [NS-1:0] dOut;

  chunked_add_sub #(.NUM_SIZE(NS), .CHUNK_SIZE(CS)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .add(add),
    .dIn0(dIn0), .dIn1(dIn1), .outValid(outValid), .outReady(outReady),
    .dOut(dOut), .carry(carry), .overflow(overflow), .zero(zero),
    .negative(negative)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NS-1:0] d;
    logic c, v, z, n;
    int   due;
  } exp_t;

  exp_t mq[$];
  int   rise_q[$];
  bit   started = 1'b0;
  bit   rst_prev = 1'b0;
  bit   ov_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operands.
  function automatic exp_t model(input logic [NS-1:0] a, input logic [NS-1:0] b,
                                 input logic ad, input int due);
    exp_t   e;
    longint sa, sb, sr, smax, smin;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sr   = ad ? (sa + sb) : (sa - sb);
    smax = (longint'(1) <<< (NS - 1)) - 1;
    smin = -(longint'(1) <<< (NS - 1));
    e.v  = (sr > smax) || (sr < smin);
    e.c  = ad ? (((64'(a) + 64'(b)) >> NS) != 0) : (a >= b);
    e.d  = ad ? (a + b) : (a - b);
`ifdef CHUNKED_ADD_SUB_SAT_EN
    if (e.v) e.d = a[NS-1] ? {1'b1, {(NS-1){1'b0}}} : {1'b0, {(NS-1){1'b1}}};
`endif
    e.z   = (e.d == '0);
    e.n   = e.d[NS-1];
    e.due = due;
    return e;
  endfunction

  // Compare process: checks handshake and results every cycle.
  always @(negedge clk) begin
    if (started) begin
      if (rst_prev) begin
        chk("reset_dout", dOut, '0);
        chk("reset_flags", {carry, overflow, zero, negative}, 4'b0);
      end
      chk("inReady", inReady, (mq.size() == 0));
      if (mq.size() > 0 && cyc >= mq[0].due) begin
        chk("outValid", outValid, 1'b1);
        chk("result", {dOut, carry, overflow, zero, negative},
            {mq[0].d, mq[0].c, mq[0].v, mq[0].z, mq[0].n});
      end else begin
        chk("outValid", outValid, 1'b0);
      end
    end
    if (!rstN) begin
      started  = 1'b1;
      rst_prev = 1'b1;
      mq.delete();
    end else begin
      rst_prev = 1'b0;
      if (started) begin
        if (mq.size() > 0 && cyc >= mq[0].due) begin
          if (outReady) void'(mq.pop_front());
        end else if (mq.size() == 0 && inValid) begin
          mq.push_back(model(dIn0, dIn1, add, cyc + 1 + NCH));
        end
      end
    end
    if (outValid && !ov_prev) rise_q.push_back(cyc);
    ov_prev = outValid;
  end

  function automatic logic [NS-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(NS-1){1'b0}}};
      3:       return {1'b0, {(NS-1){1'b1}}};
      4:       return NS'(1);
      default: return NS'($urandom);
    endcase
  endfunction

  // Present an operation and return once it has been accepted.
  task automatic issue(input logic [NS-1:0] a, input logic [NS-1:0] b,
                       input logic ad, output int t_acc);
    int k;
    k = 0;
    inValid = 1'b1; dIn0 = a; dIn1 = b; add = ad;
    do begin @(negedge clk); k++; end while (!inReady && k < 100);
    if (!inReady) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    t_acc   = cyc;
    inValid = 1'b0;
    dIn0    = NS'($urandom);
    dIn1    = NS'($urandom);
    add     = 1'($urandom_range(0, 1));
  endtask

  task automatic directed(input string nm, input logic [NS-1:0] a, input logic [NS-1:0] b,
                          input logic ad, input int hold, input logic [NS-1:0] ed,
                          input logic ec, input logic ev, input logic ez, input logic en);
    int t_acc, k;
    issue(a, b, ad, t_acc);
    k = 0;
    do begin @(negedge clk); k++; end while (!outValid && k < 40);
    if (!outValid) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_latency"}, 64'(cyc - t_acc), 64'(NCH));
      chk({nm, "_dout"}, dOut, ed);
      chk({nm, "_flags"}, {carry, overflow, zero, negative}, {ec, ev, ez, en});
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      // New requests during DONE must be ignored.
      inValid = 1'b1; dIn0 = 32'h0000_0005; dIn1 = 32'h0000_0007; add = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      inValid = 1'b0;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  initial begin
    int t, k;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    directed("add_carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b1, 0,
             32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("sub_to_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, 0,
             32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CHUNKED_ADD_SUB_SAT_EN
    directed("add_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0,
             32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    directed("add_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    // Reset during the second BUSY cycle discards the operation.
    issue(32'h0000_1111, 32'h0000_2222, 1'b1, t);
    @(posedge clk); #1 rstN = 1'b0;
    @(posedge clk); #1 rstN = 1'b1;
    @(negedge clk);
    chk("midop_rst_inReady", inReady, 1'b1);
    chk("midop_rst_outValid", outValid, 1'b0);
    chk("midop_rst_dout", dOut, '0);
    chk("midop_rst_flags", {carry, overflow, zero, negative}, 4'b0);
    @(posedge clk); #1;

    directed("backpressure", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5,
             32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CHUNKED_ADD_SUB_SAT_EN
    directed("sub_most_negative", 32'h0000_0000, 32'h8000_0000, 1'b0, 0,
             32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    directed("sub_most_negative", 32'h0000_0000, 32'h8000_0000, 1'b0, 0,
             32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    // Back-to-back issue with the consumer always ready.
    outReady = 1'b1;
    rise_q.delete();
    issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, t);
    issue(32'h0000_0010, 32'h0000_0020, 1'b0, t);
    k = 0;
    while (rise_q.size() < 2 && k < 100) begin @(negedge clk); k++; end
    if (rise_q.size() < 2) chk("b2b_timeout", 64'd0, 64'd1);
    else chk("b2b_interval", 64'(rise_q[1] - rise_q[0]), 64'(NCH + 2));
    @(posedge clk); #1 outReady = 1'b0;

    // Randomized traffic, random backpressure, occasional reset.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rstN     = ($urandom_range(0, 149) != 0);
      inValid  = ($urandom_range(0, 2) != 0);
      dIn0     = pick();
      dIn1     = pick();
      add      = 1'($urandom_range(0, 1));
      outReady = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rstN = 1'b1; inValid = 1'b0; outReady = 1'b1;
    repeat (2 * NCH + 6) @(posedge clk);
    #1 outReady = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
- Multi-cycle, parametrised add/subtract unit for the RV32I datapath.
- Processes operands CHUNK_SIZE bits per cycle over a registered carry chain, so wide adds need no long combinational carry path.
- Reports carry, signed overflow, zero and negative flags.
- Sits between the operand-select stage and writeback, with a valid/ready handshake on both sides.

Parameters:
- NUM_SIZE, 32: operand/result width in bits.
- CHUNK_SIZE, 8: bits processed per cycle. NUM_SIZE must be an integer multiple of CHUNK_SIZE; if not, fail elaboration.
- NUM_CHUNKS, NUM_SIZE/CHUNK_SIZE: derived (localparam). Latency in BUSY cycles.

Ports:
- clk  input  1  rising-edge clock
- rstN  input  1  synchronous active-low reset
- inValid  input  1  operands and op are valid
- inReady  output  1  unit can accept an operation
- add  input  1  1 = dIn0 + dIn1; 0 = dIn0 - dIn1
- dIn0  input  NUM_SIZE  addend / minuend
- dIn1  input  NUM_SIZE  addend / subtrahend
- outValid  output  1  result and flags are valid
- outReady  input  1  consumer accepts result
- dOut  output  NUM_SIZE  result
- carry  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  dOut == 0
- negative  output  1  dOut[NUM_SIZE-1]

Behaviour:
- Reset: rstN sampled low at a rising edge forces the following, regardless of state:
  - state = IDLE
  - dOut = 0
  - carry, overflow, zero, negative, outValid = 0
  - chunk counter = 0
  - inReady = 1 from the next cycle
  - Any in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - inReady = 1, outValid = 0.
  - On inValid && inReady, latch dIn0 and the effective B operand: dIn1 if add = 1, ~dIn1 if add = 0.
  - Latch carry-in: 0 for add, 1 for sub (two's-complement subtraction as A + ~B + 1).
  - Set counter = 0 and go to BUSY.
- BUSY:
  - inReady = 0.
  - Each cycle, add chunk[counter] of A and B plus the registered carry.
  - Write the CHUNK_SIZE sum bits into the result register at position counter; register the chunk carry-out.
  - On counter == NUM_CHUNKS-1, go to DONE. Otherwise increment counter.
  - The BUSY phase lasts exactly NUM_CHUNKS cycles.
- DONE:
  - outValid = 1; dOut and flags stay stable while outValid && !outReady.
  - carry = final chunk carry-out.
  - overflow = (A[MSB] == B_eff[MSB]) && (dOut[MSB] != A[MSB]), using the latched effective B.
  - zero and negative are computed from the final dOut.
  - On outReady, go to IDLE with outValid deasserting the next cycle.
  - inReady = 0 in DONE. There is no overlap: minimum issue interval is NUM_CHUNKS + 2 cycles.
- Latency: inValid accepted at edge T; outValid first high in the cycle after edge T+NUM_CHUNKS.
- Input changes while BUSY or DONE have no effect (operands are latched).
- NUM_CHUNKS == 1: BUSY lasts one cycle; behaviour is otherwise identical.
- Sub of the most-negative number, e.g. 0 - 0x80000000: result 0x80000000, overflow = 1, carry = 0.

Optional Feature:
- Macro: CHUNKED_ADD_SUB_SAT_EN.
- When defined, and overflow = 1 in DONE, dOut is replaced by the signed saturation value:
  - A[MSB] = 0 gives {0, all 1s} (max positive).
  - A[MSB] = 1 gives {1, all 0s} (most negative).
  - overflow still reports 1; zero and negative are computed from the saturated dOut; carry is unchanged.
- When not defined, dOut is the wrapped result; no saturation logic is synthesised.

Test Plan (NUM_SIZE=32, CHUNK_SIZE=8):
- Reset mid-operation: accept an add, pull rstN low during the 2nd BUSY cycle → next cycle inReady = 1, outValid = 0, dOut = 0, all flags 0.
- Add with cross-chunk carry: add=1, 0x000000FF + 0x00000001 → after 4 BUSY cycles dOut = 0x00000100, carry = 0, overflow = 0, zero = 0. Check outValid timing against the latency rule.
- Sub to zero: add=0, 0x12345678 - 0x12345678 → dOut = 0, zero = 1, carry = 1, overflow = 0, negative = 0.
- Signed overflow: add=1, 0x7FFFFFFF + 0x00000001 → dOut = 0x80000000, overflow = 1, negative = 1. With CHUNKED_ADD_SUB_SAT_EN: dOut = 0x7FFFFFFF, negative = 0.
- Backpressure: complete 0xFFFFFFFF + 0x00000001 with outReady = 0 for 5 cycles → dOut = 0, carry = 1, zero = 1, all held stable. inReady stays 0 and new inValid is ignored until outReady = 1.
- Back-to-back: two operations issued as soon as inReady allows → second outValid arrives exactly NUM_CHUNKS + 2 cycles after the first, with correct results for both.
